// File: rtl/bcd_count_ctrl.sv
// Run/pause/stop controller around a cascaded BCD counter.
// Steps are paced by an internal prescaler; a target match latches DONE.
module bcd_count_ctrl #(
  parameter int DIGITS   = 3,
  parameter int PRESCALE = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic                clear,
  input  logic [4*DIGITS-1:0] target,
  output logic [4*DIGITS-1:0] count,
  output logic [1:0]          state,
  output logic                busy,
  output logic                step,
  output logic                wrap,
  output logic                done
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_DONE  = 2'b11;

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  cnt_q, cnt_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          step_q, step_d;
  logic          wrap_q, wrap_d;

  logic [W-1:0]  inc;
  logic          carry;
  logic          all9;
  logic          tick;

  // Ripple-carry decade increment; all9 flags the rollover case.
  always_comb begin
    inc   = cnt_q;
    carry = 1'b1;
    all9  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (cnt_q[4*i +: 4] != 4'd9) begin
        all9 = 1'b0;
      end
      if (carry) begin
        if (cnt_q[4*i +: 4] == 4'd9) begin
          inc[4*i +: 4] = 4'd0;
        end else begin
          inc[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  assign tick = (pre_q == PRE_MAX);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pre_d   = pre_q;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        pre_d = '0;
        if (!clear && start) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (clear) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          pre_d   = '0;
        end else if (stop) begin
          state_d = S_PAUSE;
        end else if (tick) begin
          pre_d  = '0;
          cnt_d  = inc;
          step_d = 1'b1;
          wrap_d = all9;
          // Invalid target digits can never equal a BCD value.
          if (inc == target) begin
            state_d = S_DONE;
          end
        end else begin
          pre_d = pre_q + PW'(1);
        end
      end
      S_PAUSE: begin
        if (clear) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          pre_d   = '0;
        end else if (!stop && start) begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        if (clear) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          pre_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pre_q   <= '0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = cnt_q;
  assign state = state_q;
  assign busy  = (state_q == S_RUN);
  assign done  = (state_q == S_DONE);
  assign step  = step_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Directed bench for bcd_count_ctrl (DIGITS=2, PRESCALE=4).
// Expected outputs are queued per step and compared after the edge.
module tb_bcd_count_ctrl;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] RUN   = 2'b01;
  localparam logic [1:0] PAUSE = 2'b10;
  localparam logic [1:0] DONE  = 2'b11;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] target = 8'hFF;
  logic [7:0] count;
  logic [1:0] state;
  logic       busy, step, wrap, done;

  int total = 0;
  int bad = 0;

  typedef struct {
    string      tag;
    logic [7:0] cnt;
    logic [1:0] st;
    logic       stp;
    logic       wrp;
  } exp_t;

  exp_t exp_q[$];

  bcd_count_ctrl #(.DIGITS(2), .PRESCALE(4)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .clear(clear), .target(target), .count(count),
    .state(state), .busy(busy), .step(step),
    .wrap(wrap), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(int n);
    return {4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  task automatic cmp(string tag, logic [7:0] obs, logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(string tag, logic [7:0] c, logic [1:0] s,
                      logic p, logic w);
    exp_t e;
    e.tag = tag; e.cnt = c; e.st = s; e.stp = p; e.wrp = w;
    exp_q.push_back(e);
  endtask

  task automatic check_q();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cmp({e.tag, ".count"}, count, e.cnt);
      cmp({e.tag, ".state"}, 8'(state), 8'(e.st));
      cmp({e.tag, ".busy"}, 8'(busy), 8'(e.st == RUN));
      cmp({e.tag, ".done"}, 8'(done), 8'(e.st == DONE));
      cmp({e.tag, ".step"}, 8'(step), 8'(e.stp));
      cmp({e.tag, ".wrap"}, 8'(wrap), 8'(e.wrp));
    end
  endtask

  task automatic tk(string tag, logic [7:0] c, logic [1:0] s,
                    logic p, logic w);
    push(tag, c, s, p, w);
    @(posedge clk);
    #1;
    check_q();
  endtask

  initial begin
    // reset
    tk("rst_a", 8'h00, IDLE, 1'b0, 1'b0);
    reset = 1'b0;
    tk("rst_b", 8'h00, IDLE, 1'b0, 1'b0);
    tk("idle_stop", 8'h00, IDLE, 1'b0, 1'b0);

    // count to target 12
    target = 8'h12;
    start = 1'b1;
    tk("t1_go", 8'h00, RUN, 1'b0, 1'b0);
    start = 1'b0;
    for (int e = 1; e <= 48; e++) begin
      tk("t1_run", to_bcd(e / 4), (e == 48) ? DONE : RUN,
         e % 4 == 0, 1'b0);
    end
    for (int i = 0; i < 20; i++) begin
      tk("t1_hold", 8'h12, DONE, 1'b0, 1'b0);
    end
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tk("done_start", 8'h12, DONE, 1'b0, 1'b0);
    end
    stop = 1'b1;
    tk("done_stop", 8'h12, DONE, 1'b0, 1'b0);
    stop = 1'b0;
    clear = 1'b1;
    tk("done_clr", 8'h00, IDLE, 1'b0, 1'b0);
    clear = 1'b0;
    start = 1'b0;

    // carry and wrap, target never matches
    target = 8'hFF;
    start = 1'b1;
    tk("t2_go", 8'h00, RUN, 1'b0, 1'b0);
    start = 1'b0;
    for (int e = 1; e <= 420; e++) begin
      tk("t2_run", to_bcd((e / 4) % 100), RUN, e % 4 == 0,
         (e % 4 == 0) && ((e / 4) % 100 == 0));
    end
    start = 1'b1; stop = 1'b1; clear = 1'b1;
    tk("prio_all", 8'h00, IDLE, 1'b0, 1'b0);
    start = 1'b0; stop = 1'b0; clear = 1'b0;

    // pause/resume keeps prescaler phase
    start = 1'b1;
    tk("t3_go", 8'h00, RUN, 1'b0, 1'b0);
    start = 1'b0;
    for (int e = 1; e <= 13; e++) begin
      tk("t3_run", to_bcd(e / 4), RUN, e % 4 == 0, 1'b0);
    end
    stop = 1'b1;
    tk("t3_stop", 8'h03, PAUSE, 1'b0, 1'b0);
    stop = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tk("t3_hold", 8'h03, PAUSE, 1'b0, 1'b0);
    end
    start = 1'b1;
    tk("t3_res", 8'h03, RUN, 1'b0, 1'b0);
    start = 1'b0;
    tk("t3_r1", 8'h03, RUN, 1'b0, 1'b0);
    tk("t3_r2", 8'h03, RUN, 1'b0, 1'b0);
    tk("t3_r3", 8'h04, RUN, 1'b1, 1'b0);

    // stop on a step edge suppresses it
    tk("col_1", 8'h04, RUN, 1'b0, 1'b0);
    tk("col_2", 8'h04, RUN, 1'b0, 1'b0);
    tk("col_3", 8'h04, RUN, 1'b0, 1'b0);
    stop = 1'b1;
    tk("col_hit", 8'h04, PAUSE, 1'b0, 1'b0);
    stop = 1'b0;
    tk("col_after", 8'h04, PAUSE, 1'b0, 1'b0);
    clear = 1'b1;
    tk("pause_clr", 8'h00, IDLE, 1'b0, 1'b0);
    clear = 1'b0;

    // async reset at count 37, just after a step edge
    start = 1'b1;
    tk("t4_go", 8'h00, RUN, 1'b0, 1'b0);
    start = 1'b0;
    for (int e = 1; e <= 148; e++) begin
      tk("t4_run", to_bcd(e / 4), RUN, e % 4 == 0, 1'b0);
    end
    reset = 1'b1;
    #1;
    push("arst", 8'h00, IDLE, 1'b0, 1'b0);
    check_q();
    tk("arst_hold", 8'h00, IDLE, 1'b0, 1'b0);
    reset = 1'b0;
    start = 1'b1;
    tk("t4_rego", 8'h00, RUN, 1'b0, 1'b0);
    start = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tk("t4_rerun", to_bcd(e / 4), RUN, e % 4 == 0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
